// File: rtl/nf10_upb_util_pkg.sv
// Shared helpers for the delay-line / drain-buffer family.
package nf10_upb_util_pkg;

  // Ceiling log2, usable in constant expressions; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_drain_buffer_if.sv
// Credit, pipeline-output and downstream handshake signals of the drain buffer.
interface delay_drain_buffer_if #(
  parameter int unsigned C_DATA_WIDTH = 310
);

  logic                    issue;
  logic                    issue_allow;
  logic                    pipe_valid;
  logic [C_DATA_WIDTH-1:0] pipe_data;
  logic                    out_valid;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic                    out_ready;

  // Environment side: launches items, feeds the pipeline output, consumes the head.
  modport master (
    output issue,
    input  issue_allow,
    output pipe_valid,
    output pipe_data,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  // Buffer side.
  modport slave (
    input  issue,
    output issue_allow,
    input  pipe_valid,
    input  pipe_data,
    output out_valid,
    output out_data,
    input  out_ready
  );

endinterface

// File: rtl/delay_drain_buffer_storage.sv
// Entry array: one synchronous write port, one asynchronous read port, not reset.
module delay_drain_buffer_storage #(
  parameter int unsigned C_DATA_WIDTH = 310,
  parameter int unsigned C_DEPTH      = 8,
  parameter int unsigned C_ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [C_ADDR_WIDTH-1:0] i_waddr,
  input  logic [C_DATA_WIDTH-1:0] i_wdata,
  input  logic [C_ADDR_WIDTH-1:0] i_raddr,
  output logic [C_DATA_WIDTH-1:0] o_rdata
);

  logic [C_DATA_WIDTH-1:0] r_mem [C_DEPTH];

  // Write the arriving item into its slot.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Fall-through read of the head slot.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/delay_drain_buffer.sv
// Drain buffer behind a fixed-latency pipeline: credits upstream, valid/ready downstream.
module delay_drain_buffer
  import nf10_upb_util_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH   = 310,
  parameter int unsigned C_DEPTH        = 8,
  parameter int unsigned C_PIPE_LATENCY = 5
) (
  input  logic                             clk,
  input  logic                             resetn,
  delay_drain_buffer_if.slave              bus,
  output logic [clog2(C_DEPTH + 1) - 1:0]  occupancy,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  localparam int unsigned CW = clog2(C_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (clog2(C_DEPTH) > 0) ? clog2(C_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(C_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(C_DEPTH - 1);

  // Parameter sanity at elaboration.
  if (C_DEPTH < 2) begin : g_bad_depth
    $error("delay_drain_buffer: C_DEPTH must be >= 2");
  end
  if (C_PIPE_LATENCY == 0) begin : g_bad_latency
    $error("delay_drain_buffer: C_PIPE_LATENCY must be >= 1");
  end

  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_occupancy;
  logic [CW-1:0]           r_inflight;
  logic [CW-1:0]           r_reserved;
  logic                    r_err_overflow;
  logic                    r_err_underflow;

  logic                    w_issue_allow;
  logic                    w_out_valid;
  logic                    w_issue_ok;
  logic                    w_pop;
  logic                    w_unissued;
  logic                    w_store;
  logic                    w_drop;
  logic                    w_overflow_evt;
  logic [CW-1:0]           w_occ_nxt;
  logic [CW-1:0]           w_inflight_nxt;
  logic [SW-1:0]           w_sum;
  logic [CW-1:0]           w_reserved_nxt;
  logic [C_DATA_WIDTH-1:0] w_rdata;

  // Credit and head-valid views of the registered counters.
  assign w_issue_allow = (r_reserved < DEPTH_C);
  assign w_out_valid   = (r_occupancy != '0);

  // Per-cycle events and the net effect on each counter.
  always_comb begin
    w_issue_ok     = bus.issue && w_issue_allow;
    w_pop          = w_out_valid && bus.out_ready;
    w_unissued     = bus.pipe_valid && (r_inflight == '0);
    // A full buffer still accepts an arrival when the head leaves in the same cycle.
    w_store        = bus.pipe_valid && ((r_occupancy != DEPTH_C) || w_pop);
    w_drop         = bus.pipe_valid && !w_store;
    w_overflow_evt = (bus.issue && !w_issue_allow) || w_drop;
    w_occ_nxt      = r_occupancy + CW'(w_store) - CW'(w_pop);
    w_inflight_nxt = r_inflight + CW'(w_issue_ok) - CW'(bus.pipe_valid && !w_unissued);
    // Reserved tracks inflight + occupancy; clamp only matters after unissued arrivals.
    w_sum          = SW'(w_occ_nxt) + SW'(w_inflight_nxt);
    w_reserved_nxt = (w_sum > SW'(C_DEPTH)) ? DEPTH_C : w_sum[CW-1:0];
  end

  // Pointers, counters and sticky error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_occupancy     <= '0;
      r_inflight      <= '0;
      r_reserved      <= '0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      r_occupancy <= w_occ_nxt;
      r_inflight  <= w_inflight_nxt;
      r_reserved  <= w_reserved_nxt;
      if (w_overflow_evt) begin
        r_err_overflow <= 1'b1;
      end
      if (w_unissued) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  delay_drain_buffer_storage #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_DEPTH      (C_DEPTH),
    .C_ADDR_WIDTH (PW)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.pipe_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Output drive.
  assign bus.issue_allow = w_issue_allow;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_rdata;
  assign occupancy       = r_occupancy;
  assign err_overflow    = r_err_overflow;
  assign err_underflow   = r_err_underflow;

endmodule

// File: tb/tb_delay_drain_buffer.sv
// Self-checking bench for delay_drain_buffer: vector table, directed sequences, random stream.
module tb_delay_drain_buffer;
  import nf10_upb_util_pkg::*;

  localparam int unsigned W   = 310;
  localparam int unsigned D   = 8;
  localparam int unsigned LAT = 5;
  localparam int unsigned CW  = clog2(D + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic [CW-1:0] occupancy;
  logic          err_overflow;
  logic          err_underflow;

  always #5 clk = ~clk;

  delay_drain_buffer_if #(.C_DATA_WIDTH(W)) bus ();

  delay_drain_buffer #(
    .C_DATA_WIDTH   (W),
    .C_DEPTH        (D),
    .C_PIPE_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .occupancy     (occupancy),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue of stored items plus a count of items launched but not yet emerged.
  logic [W-1:0] m_q [$];
  int           m_inflight;
  bit           m_ovf;
  bit           m_udf;

  // Emulated fixed-latency pipeline feeding the buffer.
  logic [W:0]   pipe_sr [LAT];
  int unsigned  seq;
  logic [W-1:0] popped [$];

  typedef struct {
    bit          rst;
    bit          iss;
    bit          pv;
    logic [15:0] d;
    bit          rdy;
    bit          ov;
    logic [15:0] od;
    int          occ;
    bit          allow;
    bit          ovf;
    bit          udf;
  } vec_t;

  vec_t tbl [20];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit m_allow();
    return (m_inflight + m_q.size()) < int'(D);
  endfunction

  function automatic logic [W-1:0] mkdata(input int unsigned s);
    logic [W-1:0] v;
    v = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    v[31:0] = s;
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk1({tag, " out_valid"}, bus.out_valid, m_q.size() != 0);
    if (m_q.size() != 0) chkw({tag, " out_data"}, bus.out_data, m_q[0]);
    chki({tag, " occupancy"}, int'(occupancy), m_q.size());
    chk1({tag, " issue_allow"}, bus.issue_allow, m_allow());
    chk1({tag, " err_overflow"}, err_overflow, m_ovf);
    chk1({tag, " err_underflow"}, err_underflow, m_udf);
  endtask

  task automatic clear_model();
    m_q.delete();
    m_inflight = 0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
    popped.delete();
    for (int i = 0; i < int'(LAT); i++) pipe_sr[i] = '0;
    bus.issue      = 1'b0;
    bus.pipe_valid = 1'b0;
    bus.pipe_data  = '0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    #1;
    check_model("reset");
  endtask

  // Drive one cycle of inputs, advance the model from the pre-edge state, then clock.
  task automatic apply(input bit iss, input bit pv, input logic [W-1:0] d, input bit rdy);
    bit allow;
    bit pop;
    bit full;
    int old_inf;
    bus.issue      = iss;
    bus.pipe_valid = pv;
    bus.pipe_data  = d;
    bus.out_ready  = rdy;
    allow   = m_allow();
    pop     = (m_q.size() != 0) && rdy;
    full    = (m_q.size() == int'(D));
    old_inf = m_inflight;
    if (iss && !allow) m_ovf = 1'b1;
    if (pv && old_inf == 0) m_udf = 1'b1;
    if (iss && allow) m_inflight++;
    if (pv && old_inf != 0) m_inflight--;
    if (pop) void'(m_q.pop_front());
    if (pv) begin
      if (!full || pop) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle with a well-behaved upstream: issues only under credit, items emerge LAT cycles later.
  task automatic cycle(input bit want_iss, input bit rdy, input bit inj = 1'b0,
                       input logic [W-1:0] inj_d = '0);
    bit           iss;
    bit           pv;
    logic [W-1:0] d;
    iss = want_iss && m_allow();
    pv  = pipe_sr[LAT-1][W] | inj;
    d   = inj ? inj_d : pipe_sr[LAT-1][W-1:0];
    for (int i = int'(LAT) - 1; i > 0; i--) pipe_sr[i] = pipe_sr[i-1];
    pipe_sr[0] = iss ? {1'b1, mkdata(seq)} : '0;
    if (iss) seq++;
    if (bus.out_valid && rdy) popped.push_back(bus.out_data);
    apply(iss, pv, d, rdy);
    check_model("cyc");
  endtask

  function automatic vec_t mk(bit rst, bit iss, bit pv, logic [15:0] d, bit rdy,
                              bit ov, logic [15:0] od, int occ, bit allow, bit ovf, bit udf);
    vec_t v;
    v.rst = rst; v.iss = iss; v.pv = pv; v.d = d; v.rdy = rdy;
    v.ov = ov; v.od = od; v.occ = occ; v.allow = allow; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  initial begin
    logic [W-1:0] inj;
    int           cyc;

    resetn = 1'b0;
    seq    = 0;
    clear_model();

    // Single item through the buffer, then unissued arrival and illegal issue.
    tbl[0]  = mk(1, 1, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++)
      tbl[i] = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 16'h00A5, 1,  1, 16'h00A5, 1, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 1, 16'h0033, 0,  1, 16'h0033, 1, 1, 0, 1);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 0, 1);
    for (int i = 10; i <= 16; i++)
      tbl[i] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1);
    tbl[17] = mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 1);
    tbl[18] = mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 1, 1);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].iss, tbl[i].pv, W'(tbl[i].d), tbl[i].rdy);
      chk1($sformatf("vec%0d out_valid", i), bus.out_valid, tbl[i].ov);
      if (tbl[i].ov) chkw($sformatf("vec%0d out_data", i), bus.out_data, W'(tbl[i].od));
      chki($sformatf("vec%0d occupancy", i), int'(occupancy), tbl[i].occ);
      chk1($sformatf("vec%0d issue_allow", i), bus.issue_allow, tbl[i].allow);
      chk1($sformatf("vec%0d err_overflow", i), err_overflow, tbl[i].ovf);
      chk1($sformatf("vec%0d err_underflow", i), err_underflow, tbl[i].udf);
    end

    // Credit exhaustion then in-order drain.
    do_reset();
    seq = 1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    chk1("exhaust issue_allow", bus.issue_allow, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    chki("exhaust occupancy", int'(occupancy), 8);
    cycle(1'b0, 1'b1);
    chk1("first_pop issue_allow", bus.issue_allow, 1'b1);
    chki("first_pop occupancy", int'(occupancy), 7);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
    chki("drain count", popped.size(), 8);
    for (int i = 0; i < popped.size(); i++)
      chki($sformatf("drain order %0d", i), int'(popped[i][31:0]), i + 1);

    // Full buffer with arrival and pop in the same cycle.
    do_reset();
    seq = 1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    inj = mkdata(99);
    cycle(1'b0, 1'b1, 1'b1, inj);
    chki("full_swap occupancy", int'(occupancy), 8);
    chk1("full_swap err_overflow", err_overflow, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
    chki("full_swap count", popped.size(), 9);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      chki($sformatf("full_swap order %0d", i), int'(popped[i][31:0]), i + 1);
    if (popped.size() == 9) chkw("full_swap last", popped[8], inj);

    // Random stream of 20 items with random backpressure, wrapping the pointers.
    do_reset();
    seq = 0;
    cyc = 0;
    while (popped.size() < 20 && cyc < 600) begin
      cycle((seq < 20) && ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chki("random count", popped.size(), 20);
    for (int i = 0; i < popped.size(); i++)
      chki($sformatf("random order %0d", i), int'(popped[i][31:0]), i);

    // Asynchronous reset with five items stored.
    do_reset();
    seq = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    chki("pre_reset occupancy", int'(occupancy), 5);
    #3 resetn = 1'b0;
    #1;
    chk1("async_reset out_valid", bus.out_valid, 1'b0);
    chki("async_reset occupancy", int'(occupancy), 0);
    chk1("async_reset issue_allow", bus.issue_allow, 1'b1);
    clear_model();
    @(posedge clk);
    #3 resetn = 1'b1;
    cycle(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
